// File: rtl/bcd_share_ctrl.sv
// Shared sequential binary-to-BCD converter for the minute and second display channels.
// Optional macro BCD_SHARE_FAST_EN: two correct-then-shift steps per SHIFT cycle.
module bcd_share_ctrl #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_m,
  input  logic [IN_W-1:0]  bin_m,
  output logic             ack_m,
  output logic [OUT_W-1:0] dout_m,
  input  logic             req_s,
  input  logic [IN_W-1:0]  bin_s,
  output logic             ack_s,
  output logic [OUT_W-1:0] dout_s,
  output logic             busy
);

  localparam int NIB = OUT_W / 4;
`ifdef BCD_SHARE_FAST_EN
  localparam int STEPS = IN_W / 2;
`else
  localparam int STEPS = IN_W;
`endif
  localparam int CNT_W = $clog2(STEPS + 1);
  localparam int W_W   = OUT_W + IN_W;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state_q, state_d;
  logic [OUT_W-1:0]   acc_q, acc_d;
  logic [IN_W-1:0]    sreg_q, sreg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               chan_q, chan_d;   // 0 = minute, 1 = second
  logic               rr_q, rr_d;       // 1 = seconds win the next tie
  logic [OUT_W-1:0]   dout_m_q, dout_m_d, dout_s_q, dout_s_d;
  logic               ack_m_q, ack_m_d, ack_s_q, ack_s_d;
  logic               busy_q, busy_d;
  logic [W_W-1:0]     step1, step;
  logic               grant_s;

  // Every nibble is corrected from its own pre-shift value, then {acc, sreg} shifts left.
  function automatic logic [W_W-1:0] dabble_step(input logic [W_W-1:0] v);
    logic [W_W-1:0] t;
    t = v;
    for (int i = 0; i < NIB; i++) begin
      if (t[IN_W+4*i +: 4] > 4'd4)
        t[IN_W+4*i +: 4] = t[IN_W+4*i +: 4] + 4'd3;
    end
    return {t[W_W-2:0], 1'b0};
  endfunction

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    sreg_d   = sreg_q;
    cnt_d    = cnt_q;
    chan_d   = chan_q;
    rr_d     = rr_q;
    dout_m_d = dout_m_q;
    dout_s_d = dout_s_q;
    ack_m_d  = 1'b0;
    ack_s_d  = 1'b0;
    grant_s  = req_s && (!req_m || rr_q);
    step1    = dabble_step({acc_q, sreg_q});
`ifdef BCD_SHARE_FAST_EN
    step     = dabble_step(step1);
`else
    step     = step1;
`endif
    case (state_q)
      IDLE: begin
        if (req_m || req_s) begin
          chan_d  = grant_s;
          sreg_d  = grant_s ? bin_s : bin_m;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {acc_d, sreg_d} = step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(STEPS - 1))
          state_d = DONE;
      end
      DONE: begin
        if (chan_q) begin
          dout_s_d = acc_q;
          ack_s_d  = 1'b1;
        end else begin
          dout_m_d = acc_q;
          ack_m_d  = 1'b1;
        end
        rr_d    = ~chan_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      sreg_q   <= '0;
      cnt_q    <= '0;
      chan_q   <= 1'b0;
      rr_q     <= 1'b0;
      dout_m_q <= '0;
      dout_s_q <= '0;
      ack_m_q  <= 1'b0;
      ack_s_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      sreg_q   <= sreg_d;
      cnt_q    <= cnt_d;
      chan_q   <= chan_d;
      rr_q     <= rr_d;
      dout_m_q <= dout_m_d;
      dout_s_q <= dout_s_d;
      ack_m_q  <= ack_m_d;
      ack_s_q  <= ack_s_d;
      busy_q   <= busy_d;
    end
  end

  assign ack_m  = ack_m_q;
  assign ack_s  = ack_s_q;
  assign dout_m = dout_m_q;
  assign dout_s = dout_s_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_bcd_share_ctrl.sv
// Directed bench for bcd_share_ctrl: expected results queued at request time, checked on ack.
module tb_bcd_share_ctrl;

`ifdef BCD_SHARE_FAST_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 10;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_m, req_s, ack_m, ack_s, busy;
  logic [7:0]  bin_m, bin_s;
  logic [11:0] dout_m, dout_s;

  int checks = 0;
  int errors = 0;

  typedef struct {bit ch; logic [11:0] val;} sb_t;
  sb_t sb_q[$];
  logic [11:0] exp_m = '0;
  logic [11:0] exp_s = '0;

  bcd_share_ctrl #(.IN_W(8), .OUT_W(12)) dut (
    .clk(clk), .rst(rst),
    .req_m(req_m), .bin_m(bin_m), .ack_m(ack_m), .dout_m(dout_m),
    .req_s(req_s), .bin_s(bin_s), .ack_s(ack_s), .dout_s(dout_s),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "simulation did not finish");
  end

  function automatic logic [11:0] bcd(input int v);
    return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit ch, input int v);
    sb_t e;
    e.ch  = ch;
    e.val = bcd(v);
    sb_q.push_back(e);
  endtask

  // Waits for the next ack, compares against the scoreboard head and the held value of the other channel.
  task automatic wait_ack(input string tag, input int exp_lat, input bit drop);
    int   n, busy_n;
    bit   seen;
    sb_t  e;
    n = 0; busy_n = 0; seen = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (busy) busy_n++;
      if (ack_m || ack_s) begin
        seen = 1;
        check({tag, "_ack_excl"}, 32'(ack_m & ack_s), 32'd0);
        if (sb_q.size() == 0) begin
          check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          if (e.ch) exp_s = e.val; else exp_m = e.val;
          check({tag, "_chan"}, 32'(ack_s), 32'(e.ch));
          check({tag, "_dout_m"}, 32'(dout_m), 32'(exp_m));
          check({tag, "_dout_s"}, 32'(dout_s), 32'(exp_s));
        end
        check({tag, "_latency"}, 32'(n), 32'(exp_lat));
        check({tag, "_busy_cycles"}, 32'(busy_n), 32'(exp_lat - 1));
        if (drop) begin
          if (ack_m) req_m = 1'b0;
          if (ack_s) req_s = 1'b0;
        end
      end
    end
    if (!seen) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    check({tag, "_ack_m_low"}, 32'(ack_m), 32'd0);
    check({tag, "_ack_s_low"}, 32'(ack_s), 32'd0);
    check({tag, "_busy_low"}, 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_m = '0;
    exp_s = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_m = 1'b0; req_s = 1'b0; bin_m = '0; bin_s = '0;
    repeat (2) @(negedge clk);
    check("rst_dout_m", 32'(dout_m), 32'd0);
    check("rst_dout_s", 32'(dout_s), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_acks", 32'({ack_m, ack_s}), 32'd0);
    rst = 1'b0;
    idle_check("idle0");

    // Single minute request
    bin_m = 8'd45; req_m = 1'b1; push(0, 45);
    wait_ack("m45", LAT, 1);
    $display("txn m45: dout_m=%03h dout_s=%03h", dout_m, dout_s);
    idle_check("m45_after");

    // Seconds, including the full-range maximum
    bin_s = 8'd59; req_s = 1'b1; push(1, 59);
    wait_ack("s59", LAT, 1);
    $display("txn s59: dout_s=%03h dout_m=%03h", dout_s, dout_m);
    bin_s = 8'd255; req_s = 1'b1; push(1, 255);
    wait_ack("s255", LAT, 1);
    $display("txn s255: dout_s=%03h dout_m=%03h", dout_s, dout_m);
    idle_check("s255_after");

    // Simultaneous requests after reset: minute first
    do_reset();
    bin_m = 8'd12; bin_s = 8'd34; req_m = 1'b1; req_s = 1'b1;
    push(0, 12); push(1, 34);
    wait_ack("tie_m12", LAT, 1);
    $display("txn tie m12: dout_m=%03h", dout_m);
    wait_ack("tie_s34", LAT, 1);
    $display("txn tie s34: dout_s=%03h", dout_s);

    // Both held permanently: strict alternation
    bin_m = 8'd7; bin_s = 8'd8; req_m = 1'b1; req_s = 1'b1;
    push(0, 7); push(1, 8); push(0, 7); push(1, 8);
    for (int i = 0; i < 4; i++) begin
      wait_ack($sformatf("alt%0d", i), LAT, 0);
      $display("txn alt%0d: ack_m=%0b ack_s=%0b dout_m=%03h dout_s=%03h", i, ack_m, ack_s, dout_m, dout_s);
    end
    req_m = 1'b0; req_s = 1'b0;
    idle_check("alt_after");

    // bin_m changes after grant must not disturb the conversion
    bin_m = 8'd45; req_m = 1'b1; push(0, 45);
    repeat (2) @(negedge clk);
    bin_m = 8'd99;
    wait_ack("late_bin", LAT - 2, 1);
    $display("txn late_bin: dout_m=%03h", dout_m);

    // Reset during the 5th SHIFT cycle aborts without ack
    bin_m = 8'd77; req_m = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("abort_noack%0d", i), 32'({ack_m, ack_s}), 32'd0);
    end
    rst = 1'b1;
    #1;
    check("abort_dout_m", 32'(dout_m), 32'd0);
    check("abort_dout_s", 32'(dout_s), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_acks", 32'({ack_m, ack_s}), 32'd0);
    exp_m = '0; exp_s = '0;
    bin_m = 8'd30; push(0, 30);
    @(negedge clk);
    rst = 1'b0;
    wait_ack("post_abort_m30", LAT, 1);
    $display("txn post_abort m30: dout_m=%03h", dout_m);
    idle_check("final");

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
